// File: rtl/red_pitaya_acq_pkg.sv
// Shared types and constants for the ADC acquisition channel.
// The trigger-source codes match the values software writes to trig_src_i.
package red_pitaya_acq_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_POST, ST_DONE} acq_state_e;

   localparam logic [2:0] TRIG_NONE  = 3'd0;
   localparam logic [2:0] TRIG_SW    = 3'd1;
   localparam logic [2:0] TRIG_EXT_P = 3'd2;
   localparam logic [2:0] TRIG_EXT_N = 3'd3;
   localparam logic [2:0] TRIG_LVL_P = 3'd4;
   localparam logic [2:0] TRIG_LVL_N = 3'd5;

   localparam int MAX_DEC_LOG = 16;

   // Clamp a 16-bit signed value into the 14-bit range, returned as 15-bit signed.
   function automatic logic signed [14:0] sat14(input logic signed [15:0] v);
      if (v > 16'sd8191)
         return 15'sd8191;
      else if (v < -16'sd8192)
         return -15'sd8192;
      else
         return v[14:0];
   endfunction

endpackage

// File: rtl/red_pitaya_trig_deb.sv
// External trigger conditioner: 3-FF synchroniser followed by independent
// rising/falling edge debounce, emitting single-cycle edge pulses.
module red_pitaya_trig_deb
   import red_pitaya_acq_pkg::*;
#(
   parameter int DEB_W = 20
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ext_i,
   input  logic [DEB_W-1:0] deb_len_i,
   output logic             ext_p_o,
   output logic             ext_n_o
);

   // [2:0] are the synchroniser stages, [3] holds the previous synchronised level.
   logic [3:0]       sync_q, sync_d;
   logic [DEB_W-1:0] deb_p_q, deb_p_d, deb_n_q, deb_n_d;

   always_comb begin
      sync_d  = {sync_q[2:0], ext_i};
      ext_p_o = sync_q[2] & ~sync_q[3] & (deb_p_q == '0);
      ext_n_o = ~sync_q[2] & sync_q[3] & (deb_n_q == '0);

      deb_p_d = deb_p_q;
      if (ext_p_o)
         deb_p_d = deb_len_i;
      else if (deb_p_q != '0)
         deb_p_d = deb_p_q - DEB_W'(1);

      deb_n_d = deb_n_q;
      if (ext_n_o)
         deb_n_d = deb_len_i;
      else if (deb_n_q != '0)
         deb_n_d = deb_n_q - DEB_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         deb_p_q <= '0;
         deb_n_q <= '0;
      end else begin
         sync_q  <= sync_d;
         deb_p_q <= deb_p_d;
         deb_n_q <= deb_n_d;
      end
   end

endmodule

// File: rtl/red_pitaya_acq_ch.sv
// Single-channel ADC acquisition: decimate/average, circular buffer write,
// trigger selection and post-trigger stop, with CPU readback port.
module red_pitaya_acq_ch
   import red_pitaya_acq_pkg::*;
#(
   parameter int RSZ   = 14,
   parameter int DEB_W = 20
) (
   input  logic             adc_clk_i,
   input  logic             adc_rst_i,
   input  logic [13:0]      adc_dat_i,
   input  logic             trig_sw_i,
   input  logic             trig_ext_i,
   input  logic [2:0]       trig_src_i,
   output logic             trig_o,
   input  logic             set_arm_i,
   input  logic             set_rst_i,
   input  logic [4:0]       set_dec_log_i,
   input  logic             set_avg_i,
   input  logic [13:0]      set_thr_i,
   input  logic [13:0]      set_hyst_i,
   input  logic [31:0]      set_dly_i,
   input  logic [DEB_W-1:0] set_deb_len_i,
   input  logic [RSZ-1:0]   buf_addr_i,
   output logic [13:0]      buf_rdata_o,
   output logic [RSZ-1:0]   wr_pnt_o,
   output logic [RSZ-1:0]   trig_pnt_o,
   output logic [3:0]       status_o
);

   acq_state_e         state_q, state_d;
   logic [15:0]        dec_cnt_q, dec_cnt_d, dec_max;
   logic [4:0]         dec_log;
   logic signed [30:0] acc_q, acc_d, acc_sum;
   logic [13:0]        first_q, first_d, smp_q, smp_d, rdata_q;
   logic               vld_q, vld_d;
   logic [RSZ-1:0]     wr_pnt_q, wr_pnt_d, trig_pnt_q, trig_pnt_d;
   logic [31:0]        post_cnt_q, post_cnt_d;
   logic               trig_q, trig_d, trig_seen_q, trig_seen_d, lvl_arm_q, lvl_arm_d;
   logic [3:0]         status_q, status_d;
   logic               run, wr_en, trig_hit, trig_acc, lvl_fire, ext_p, ext_n;
   logic signed [14:0] s15, thr15, lo15, hi15;

   logic [13:0] mem [2**RSZ];

   red_pitaya_trig_deb #(.DEB_W(DEB_W)) u_deb (
      .clk_i     (adc_clk_i),
      .rst_i     (adc_rst_i),
      .ext_i     (trig_ext_i),
      .deb_len_i (set_deb_len_i),
      .ext_p_o   (ext_p),
      .ext_n_o   (ext_n)
   );

   always_comb begin
      dec_log = (set_dec_log_i > 5'(MAX_DEC_LOG)) ? 5'(MAX_DEC_LOG) : set_dec_log_i;
      dec_max = ~(16'hFFFF << dec_log);
      acc_sum = ((dec_cnt_q == '0) ? '0 : acc_q) + 31'($signed(adc_dat_i));
      first_d = (dec_cnt_q == '0) ? adc_dat_i : first_q;

      // Level detector runs on raw samples with a hysteresis re-arm band.
      s15   = $signed({adc_dat_i[13], adc_dat_i});
      thr15 = $signed({set_thr_i[13], set_thr_i});
      lo15  = sat14($signed({{2{set_thr_i[13]}}, set_thr_i}) - $signed({2'b00, set_hyst_i}));
      hi15  = sat14($signed({{2{set_thr_i[13]}}, set_thr_i}) + $signed({2'b00, set_hyst_i}));
      lvl_arm_d = lvl_arm_q;
      lvl_fire  = 1'b0;
      if (trig_src_i == TRIG_LVL_P) begin
         lvl_fire = lvl_arm_q && (s15 >= thr15);
         if (s15 < lo15) lvl_arm_d = 1'b1;
      end else if (trig_src_i == TRIG_LVL_N) begin
         lvl_fire = lvl_arm_q && (s15 <= thr15);
         if (s15 > hi15) lvl_arm_d = 1'b1;
      end else begin
         lvl_arm_d = 1'b0;
      end
      if (lvl_fire || set_arm_i) lvl_arm_d = 1'b0;

      case (trig_src_i)
         TRIG_SW:    trig_hit = trig_sw_i;
         TRIG_EXT_P: trig_hit = ext_p;
         TRIG_EXT_N: trig_hit = ext_n;
         TRIG_LVL_P,
         TRIG_LVL_N: trig_hit = lvl_fire;
         default:    trig_hit = 1'b0;
      endcase

      run      = (state_q == ST_ARMED) || (state_q == ST_POST);
      wr_en    = vld_q && run && !set_arm_i && !set_rst_i;
      trig_acc = trig_hit && (state_q == ST_ARMED) && !set_arm_i && !set_rst_i;

      state_d     = state_q;
      dec_cnt_d   = dec_cnt_q;
      acc_d       = acc_q;
      smp_d       = smp_q;
      vld_d       = 1'b0;
      wr_pnt_d    = wr_pnt_q;
      trig_pnt_d  = trig_pnt_q;
      post_cnt_d  = post_cnt_q;
      trig_d      = 1'b0;
      trig_seen_d = trig_seen_q;

      if (run) begin
         dec_cnt_d = (dec_cnt_q == dec_max) ? '0 : dec_cnt_q + 16'd1;
         acc_d     = acc_sum;
         vld_d     = (dec_cnt_q == dec_max);
         if (vld_d) smp_d = set_avg_i ? 14'(acc_sum >>> dec_log) : first_d;
      end

      if (wr_en) begin
         wr_pnt_d = wr_pnt_q + RSZ'(1);
         if (state_q == ST_POST) begin
            post_cnt_d = post_cnt_q + 32'd1;
            if (post_cnt_q == set_dly_i) state_d = ST_DONE;
         end
      end

      // Trigger pointer marks the slot the first post-trigger sample lands in.
      if (trig_acc) begin
         state_d     = ST_POST;
         trig_d      = 1'b1;
         trig_pnt_d  = wr_pnt_d;
         post_cnt_d  = '0;
         trig_seen_d = 1'b1;
      end

      if (set_rst_i) begin
         state_d = ST_IDLE;
         vld_d   = 1'b0;
      end else if (set_arm_i) begin
         state_d     = ST_ARMED;
         dec_cnt_d   = '0;
         acc_d       = '0;
         vld_d       = 1'b0;
         wr_pnt_d    = '0;
         trig_pnt_d  = '0;
         post_cnt_d  = '0;
         trig_seen_d = 1'b0;
      end

      status_d = {state_d == ST_DONE, state_d == ST_POST,
                  (state_d == ST_ARMED) || (state_d == ST_POST), trig_seen_d};
   end

   always_ff @(posedge adc_clk_i) begin
      if (adc_rst_i) begin
         state_q     <= ST_IDLE;
         dec_cnt_q   <= '0;
         acc_q       <= '0;
         first_q     <= '0;
         smp_q       <= '0;
         vld_q       <= 1'b0;
         wr_pnt_q    <= '0;
         trig_pnt_q  <= '0;
         post_cnt_q  <= '0;
         trig_q      <= 1'b0;
         trig_seen_q <= 1'b0;
         lvl_arm_q   <= 1'b0;
         status_q    <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         dec_cnt_q   <= dec_cnt_d;
         acc_q       <= acc_d;
         first_q     <= first_d;
         smp_q       <= smp_d;
         vld_q       <= vld_d;
         wr_pnt_q    <= wr_pnt_d;
         trig_pnt_q  <= trig_pnt_d;
         post_cnt_q  <= post_cnt_d;
         trig_q      <= trig_d;
         trig_seen_q <= trig_seen_d;
         lvl_arm_q   <= lvl_arm_d;
         status_q    <= status_d;
         rdata_q     <= mem[buf_addr_i];
      end
   end

   always_ff @(posedge adc_clk_i) begin
      if (wr_en && !adc_rst_i) mem[wr_pnt_q] <= smp_q;
   end

   assign trig_o      = trig_q;
   assign buf_rdata_o = rdata_q;
   assign wr_pnt_o    = wr_pnt_q;
   assign trig_pnt_o  = trig_pnt_q;
   assign status_o    = status_q;

endmodule
